// File: rtl/input_delay_capture_array.sv
// Multi-channel input-capture block: each channel applies a selectable bitwise function to two ports,
// then sends the result down a valid-tagged pipeline and counts beats where the result differs from port_a.
module input_delay_capture_array #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      src_clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [NUM_CH*WIDTH-1:0]   port_a,
    input  logic [NUM_CH*WIDTH-1:0]   port_b,
    input  logic [1:0]                mode,
    input  logic                      clr_cnt,
    output logic [NUM_CH*WIDTH-1:0]   ref_q,
    output logic [NUM_CH*WIDTH-1:0]   out,
    output logic                      out_valid,
    output logic [NUM_CH*CNT_W-1:0]   mismatch_cnt
);

    localparam int DW = NUM_CH * WIDTH;
    localparam int CW = NUM_CH * CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]             ref_d;
    logic [DW-1:0]             comb_res;
    logic [DEPTH-1:0][DW-1:0]  res_q, res_d;
    logic [DEPTH-1:0][DW-1:0]  a_q, a_d;
    logic [DEPTH-1:0]          v_q, v_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    // The functions are purely bitwise, so applying them to the packed vector keeps channels independent.
    always_comb begin
        comb_res = port_a;
        case (mode)
            2'b00:   comb_res = port_a & port_b;
            2'b01:   comb_res = port_a | port_b;
            2'b10:   comb_res = port_a ^ port_b;
            default: comb_res = port_a;
        endcase
    end

    always_comb begin
        ref_d = port_a;
        res_d = res_q;
        a_d   = a_q;
        v_d   = v_q;

        v_d[0] = in_valid;
        if (in_valid) begin
            res_d[0] = comb_res;
            a_d[0]   = port_a;
        end

        // Data stages only load behind a valid beat, so out holds its last result through bubbles.
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
                res_d[k] = res_q[k-1];
                a_d[k]   = a_q[k-1];
            end
        end
    end

    // Clear wins over a same-cycle increment; counters stick at their maximum.
    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clr_cnt) begin
                cnt_d[c*CNT_W +: CNT_W] = '0;
            end else if (v_q[DEPTH-1]
                         && (res_q[DEPTH-1][c*WIDTH +: WIDTH] != a_q[DEPTH-1][c*WIDTH +: WIDTH])
                         && (cnt_q[c*CNT_W +: CNT_W] != CNT_MAX)) begin
                cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            res_q <= '0;
            a_q   <= '0;
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            ref_q <= ref_d;
            res_q <= res_d;
            a_q   <= a_d;
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign out          = res_q[DEPTH-1];
    assign out_valid    = v_q[DEPTH-1];
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_input_delay_capture_array.sv
// Bench for input_delay_capture_array: directed scenarios plus a randomized stream, all compared
// against a beat-queue reference model that is stepped once per clock edge.
module tb_input_delay_capture_array;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;
    localparam int DW     = NUM_CH * WIDTH;
    localparam int CW     = NUM_CH * CNT_W;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic          src_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] port_a = '0;
    logic [DW-1:0] port_b = '0;
    logic [1:0]    mode = 2'b00;
    logic          clr_cnt = 1'b0;
    logic [DW-1:0] ref_q;
    logic [DW-1:0] out;
    logic          out_valid;
    logic [CW-1:0] mismatch_cnt;

    input_delay_capture_array #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .src_clk(src_clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .port_a(port_a),
        .port_b(port_b),
        .mode(mode),
        .clr_cnt(clr_cnt),
        .ref_q(ref_q),
        .out(out),
        .out_valid(out_valid),
        .mismatch_cnt(mismatch_cnt)
    );

    always #5 src_clk = ~src_clk;

    typedef struct {
        bit            v;
        logic [DW-1:0] res;
        logic [DW-1:0] a;
    } beat_t;

    beat_t         pipe[$];
    logic [DW-1:0] exp_ref;
    logic [DW-1:0] exp_out;
    logic [DW-1:0] exp_out_a;
    bit            exp_valid;
    int            exp_cnt[NUM_CH];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [1:0] m);
        case (m)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic logic [DW-1:0] combineAll(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [1:0] m);
        logic [DW-1:0] r;
        for (int c = 0; c < NUM_CH; c++)
            r[c*WIDTH +: WIDTH] = combine(a[c*WIDTH +: WIDTH], b[c*WIDTH +: WIDTH], m);
        return r;
    endfunction

    function automatic logic [CW-1:0] packCnt();
        logic [CW-1:0] v;
        for (int c = 0; c < NUM_CH; c++)
            v[c*CNT_W +: CNT_W] = CNT_W'(exp_cnt[c]);
        return v;
    endfunction

    task automatic modelReset();
        pipe.delete();
        exp_ref   = '0;
        exp_out   = '0;
        exp_out_a = '0;
        exp_valid = 0;
        for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = 0;
    endtask

    // A beat entering at some edge is the DEPTH-th newest queue entry DEPTH-1 edges later.
    task automatic modelEdge();
        beat_t b;
        if (!rst_n) begin
            modelReset();
            return;
        end
        exp_ref = port_a;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clr_cnt)
                exp_cnt[c] = 0;
            else if (exp_valid && exp_out[c*WIDTH +: WIDTH] != exp_out_a[c*WIDTH +: WIDTH]
                     && exp_cnt[c] < CNT_SAT)
                exp_cnt[c] = exp_cnt[c] + 1;
        end
        pipe.push_back('{v: in_valid, res: combineAll(port_a, port_b, mode), a: port_a});
        if (pipe.size() == DEPTH) begin
            b = pipe.pop_front();
            exp_valid = b.v;
            if (b.v) begin
                exp_out   = b.res;
                exp_out_a = b.a;
            end
        end else begin
            exp_valid = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".ref_q"}, 64'(ref_q), 64'(exp_ref));
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        checkOutput({tag, ".out"}, 64'(out), 64'(exp_out));
        checkOutput({tag, ".cnt"}, 64'(mismatch_cnt), 64'(packCnt()));
    endtask

    // Inputs change 1 time unit after an edge; the following edge captures them and outputs are sampled 1 unit later.
    task automatic applyStimulus(input string tag, input logic v, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [1:0] m, input logic clr);
        in_valid = v;
        port_a   = a;
        port_b   = b;
        mode     = m;
        clr_cnt  = clr;
        @(posedge src_clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    function automatic logic [DW-1:0] ch0Only(input logic [WIDTH-1:0] v);
        return DW'(v);
    endfunction

    initial begin
        logic [DW-1:0] ra, rb;
        modelReset();

        // Reset held with live inputs
        for (int i = 0; i < 4; i++)
            applyStimulus("reset_hold", 1'b1, DW'($urandom), DW'($urandom), 2'($urandom), 1'b0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_cnt", 64'(mismatch_cnt), 64'd0);
        checkOutput("reset_out", 64'(out), 64'd0);
        rst_n = 1'b1;

        // Single AND beat
        applyStimulus("and_t", 1'b1, ch0Only(8'hF0), ch0Only(8'h3C), 2'b00, 1'b0);
        checkOutput("and_ref_ch0", 64'(ref_q[7:0]), 64'hF0);
        checkOutput("and_early_valid", 64'(out_valid), 64'd0);
        applyStimulus("and_t1", 1'b0, ch0Only(8'hF0), ch0Only(8'h3C), 2'b00, 1'b0);
        checkOutput("and_valid", 64'(out_valid), 64'd1);
        checkOutput("and_out", 64'(out), 64'h30);
        applyStimulus("and_t2", 1'b0, ch0Only(8'hF0), ch0Only(8'h3C), 2'b00, 1'b0);
        checkOutput("and_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("and_cnt", 64'(mismatch_cnt), 64'h1);

        // Bubble and hold, with a mode change on the bubble
        applyStimulus("bub1", 1'b1, ch0Only(8'h01), ch0Only(8'h02), 2'b01, 1'b0);
        applyStimulus("bub2", 1'b0, ch0Only(8'h00), ch0Only(8'h00), 2'b10, 1'b0);
        checkOutput("bub_v1", 64'(out_valid), 64'd1);
        checkOutput("bub_o1", 64'(out[7:0]), 64'h03);
        applyStimulus("bub3", 1'b1, ch0Only(8'h10), ch0Only(8'h20), 2'b01, 1'b0);
        checkOutput("bub_v2", 64'(out_valid), 64'd0);
        checkOutput("bub_o2", 64'(out[7:0]), 64'h03);
        applyStimulus("bub4", 1'b0, ch0Only(8'h00), ch0Only(8'h00), 2'b01, 1'b0);
        checkOutput("bub_v3", 64'(out_valid), 64'd1);
        checkOutput("bub_o3", 64'(out[7:0]), 64'h30);

        // Pass-A stream after clearing counters
        applyStimulus("pass_clr", 1'b0, '0, '0, 2'b00, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            ra = DW'($urandom);
            ra[7:0] = 8'(i);
            applyStimulus("pass", (i < 10) ? 1'b1 : 1'b0, ra, {DW{1'b1}}, 2'b11, 1'b0);
            if (i >= 1) begin
                checkOutput("pass_valid", 64'(out_valid), 64'd1);
                checkOutput("pass_out", 64'(out[7:0]), 64'(i - 1));
            end
        end
        applyStimulus("pass_flush", 1'b0, '0, '0, 2'b11, 1'b0);
        checkOutput("pass_cnt", 64'(mismatch_cnt), 64'd0);

        // Saturation, then clear against a same-cycle mismatch
        for (int i = 0; i < 20; i++)
            applyStimulus("sat", 1'b1, ch0Only(8'h00), ch0Only(8'h01), 2'b10, 1'b0);
        checkOutput("sat_cnt", 64'(mismatch_cnt[3:0]), 64'd15);
        applyStimulus("sat_clr", 1'b1, ch0Only(8'h00), ch0Only(8'h01), 2'b10, 1'b1);
        checkOutput("sat_clr_cnt", 64'(mismatch_cnt[3:0]), 64'd0);
        applyStimulus("sat_after", 1'b0, ch0Only(8'h00), ch0Only(8'h01), 2'b10, 1'b0);
        checkOutput("sat_after_cnt", 64'(mismatch_cnt[3:0]), 64'd1);

        // Mid-stream asynchronous reset
        applyStimulus("mid1", 1'b1, ch0Only(8'h0F), ch0Only(8'hF0), 2'b01, 1'b0);
        applyStimulus("mid2", 1'b1, ch0Only(8'h33), ch0Only(8'h0F), 2'b00, 1'b0);
        rst_n = 1'b0;
        #2;
        modelReset();
        checkAll("mid_rst");
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        applyStimulus("mid_post1", 1'b1, ch0Only(8'h55), ch0Only(8'hAA), 2'b10, 1'b0);
        checkOutput("mid_post1_valid", 64'(out_valid), 64'd0);
        applyStimulus("mid_post2", 1'b0, '0, '0, 2'b00, 1'b0);
        checkOutput("mid_post2_valid", 64'(out_valid), 64'd1);
        checkOutput("mid_post2_out", 64'(out[7:0]), 64'hFF);

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            ra = DW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : DW'($urandom);
            applyStimulus("rand", ($urandom_range(0, 3) != 0), ra, rb, 2'($urandom),
                          ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
